// File: rtl/fft_sdiv_24s_9s_16_seq_pkg.sv
// fft_div_pkg: widths, saturation limits and FSM encoding shared by the sequential divider.
package fft_div_pkg;
    localparam int DIVIDEND_W = 24;
    localparam int DIVISOR_W = 9;
    localparam int QUOT_W = 16;
    localparam logic [QUOT_W-1:0] QMAX = 16'h7fff;
    localparam logic [QUOT_W-1:0] QMIN = 16'h8000;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX = 2'd2,
        DONE = 2'd3
    } div_state_t;
endpackage

// File: rtl/fft_sdiv_24s_9s_16_seq_if.sv
// fft_sdiv_24s_9s_16_seq_if: operand and result handshakes of the sequential signed divider.
interface fft_sdiv_24s_9s_16_seq_if;
    import fft_div_pkg::*;
    logic in_valid;
    logic in_ready;
    logic signed [DIVIDEND_W-1:0] din0;
    logic signed [DIVISOR_W-1:0] din1;
    logic out_valid;
    logic out_ready;
    logic signed [QUOT_W-1:0] quot;
    logic signed [DIVISOR_W-1:0] rem;
    logic ovf;
    logic div0;
    modport master (
        output in_valid, din0, din1, out_ready,
        input in_ready, out_valid, quot, rem, ovf, div0
    );
    modport slave (
        input in_valid, din0, din1, out_ready,
        output in_ready, out_valid, quot, rem, ovf, div0
    );
endinterface

// File: rtl/fft_sdiv_24s_9s_16_seq_step.sv
// fft_sdiv_step: one restoring-division step on magnitudes (shift in a dividend bit, trial subtract).
module fft_sdiv_step
    import fft_div_pkg::*;
(
    input  logic [DIVISOR_W:0]   rem_in,
    input  logic                 dbit,
    input  logic [DIVISOR_W-1:0] dvsr,
    output logic [DIVISOR_W:0]   rem_out,
    output logic                 qbit
);
    logic [DIVISOR_W:0] sh;
    always_comb begin
        sh = {rem_in[DIVISOR_W-1:0], dbit};
        qbit = rem_in[DIVISOR_W] | (sh >= {1'b0, dvsr});
        rem_out = qbit ? sh - {1'b0, dvsr} : sh;
    end
endmodule

// File: rtl/fft_sdiv_24s_9s_16_seq.sv
// fft_sdiv_24s_9s_16_seq: 24s/9s -> 16s saturating radix-2 restoring divider, one quotient bit per clock.
module fft_sdiv_24s_9s_16_seq
    import fft_div_pkg::*;
(
    input logic ap_clk,
    input logic ap_rst_n,
    fft_sdiv_24s_9s_16_seq_if.slave bus
);
    div_state_t state;
    logic [4:0] cnt;
    logic [DIVIDEND_W-1:0] a;
    logic [DIVIDEND_W-1:0] q;
    logic [DIVISOR_W-1:0] b;
    logic [DIVISOR_W:0] r;
    logic [DIVISOR_W:0] r_nxt;
    logic sn;
    logic sd;
    logic qbit;
    logic neg;
    logic big;
    logic zero;
    logic [QUOT_W-1:0] fq;
    logic [DIVISOR_W-1:0] fr;

    fft_sdiv_step u_step (
        .rem_in(r),
        .dbit(a[DIVIDEND_W-1]),
        .dvsr(b),
        .rem_out(r_nxt),
        .qbit(qbit)
    );

    // a zero divisor yields an all-ones magnitude, so its result is forced from the dividend sign instead
    always_comb begin
        zero = b == '0;
        neg = sn ^ sd;
        big = neg ? (q > 24'd32768) : (|q[DIVIDEND_W-1:QUOT_W-1]);
        fq = zero ? (sn ? QMIN : QMAX) : big ? (neg ? QMIN : QMAX) : neg ? -q[QUOT_W-1:0] : q[QUOT_W-1:0];
        fr = zero ? '0 : sn ? -r[DIVISOR_W-1:0] : r[DIVISOR_W-1:0];
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
            cnt <= '0;
            a <= '0;
            q <= '0;
            b <= '0;
            r <= '0;
            sn <= 1'b0;
            sd <= 1'b0;
            bus.in_ready <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.quot <= '0;
            bus.rem <= '0;
            bus.ovf <= 1'b0;
            bus.div0 <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid && bus.in_ready) begin
                    sn <= bus.din0[DIVIDEND_W-1];
                    sd <= bus.din1[DIVISOR_W-1];
                    a <= bus.din0[DIVIDEND_W-1] ? -bus.din0 : bus.din0;
                    b <= bus.din1[DIVISOR_W-1] ? -bus.din1 : bus.din1;
                    r <= '0;
                    cnt <= 5'd23;
                    bus.in_ready <= 1'b0;
                    state <= CALC;
                end
                CALC: begin
                    a <= a << 1;
                    q <= {q[DIVIDEND_W-2:0], qbit};
                    r <= r_nxt;
                    if (cnt == 5'd0) state <= FIX;
                    else cnt <= cnt - 5'd1;
                end
                FIX: begin
                    bus.quot <= fq;
                    bus.rem <= fr;
                    bus.ovf <= !zero && big;
                    bus.div0 <= zero;
                    bus.out_valid <= 1'b1;
                    state <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    bus.in_ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fft_sdiv_24s_9s_16_seq.sv
// tb_fft_sdiv_24s_9s_16_seq: directed checks of quotient, remainder, flags, latency, backpressure and reset.
module tb_fft_sdiv_24s_9s_16_seq;
    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b1;
    int tests = 0;
    int fails = 0;

    fft_sdiv_24s_9s_16_seq_if bus ();

    fft_sdiv_24s_9s_16_seq dut (
        .ap_clk(ap_clk),
        .ap_rst_n(ap_rst_n),
        .bus(bus)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic start(input int a, input int b);
        @(negedge ap_clk);
        bus.din0 = 24'(a);
        bus.din1 = 9'(b);
        bus.in_valid = 1'b1;
        @(posedge ap_clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // counts edges after the accepting edge until out_valid, giving up at 100
    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge ap_clk);
            #1 lat++;
        end
    endtask

    task automatic retire;
        @(negedge ap_clk);
        bus.out_ready = 1'b1;
        @(posedge ap_clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #3 ap_rst_n = 1'b0;
        repeat (2) @(negedge ap_clk);
        tests++;
        if ({bus.in_ready, bus.out_valid, bus.ovf, bus.div0, bus.quot, bus.rem} !== {4'b1000, 25'd0}) begin
            $display("FAIL reset: in_ready=%b out_valid=%b ovf=%b div0=%b quot=%0d rem=%0d, want 1 0 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.ovf, bus.div0, bus.quot, bus.rem);
            fails++;
        end
        ap_rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat;
        start(1000, 7);
        wait_done(lat);
        tests++;
        if (lat != 25) begin
            $display("FAIL basic_latency: got %0d edges, want 25", lat);
            fails++;
        end
        tests++;
        if (bus.quot !== 16'sd142 || bus.rem !== 9'sd6 || bus.ovf !== 1'b0 || bus.div0 !== 1'b0) begin
            $display("FAIL basic 1000/7: quot=%0d rem=%0d ovf=%b div0=%b, want 142 6 0 0",
                     bus.quot, bus.rem, bus.ovf, bus.div0);
            fails++;
        end
        retire();
    endtask

    task automatic test_signs;
        int va[3] = '{-1000, 1000, -1000};
        int vb[3] = '{7, -7, -7};
        int eq[3] = '{-142, -142, 142};
        int er[3] = '{-6, 6, -6};
        int lat;
        for (int i = 0; i < 3; i++) begin
            start(va[i], vb[i]);
            wait_done(lat);
            tests++;
            if (bus.quot !== 16'(eq[i]) || bus.rem !== 9'(er[i]) || bus.ovf !== 1'b0 || bus.div0 !== 1'b0) begin
                $display("FAIL signs %0d/%0d: quot=%0d rem=%0d ovf=%b div0=%b, want %0d %0d 0 0",
                         va[i], vb[i], bus.quot, bus.rem, bus.ovf, bus.div0, eq[i], er[i]);
                fails++;
            end
            retire();
        end
    endtask

    // 9'sh100 is -256: the largest divisor magnitude the 9b path must carry
    task automatic test_saturation;
        int va[5] = '{8388607, -8388608, -8388608, -8355840, 8388607};
        int vb[5] = '{1, -1, -256, 255, -256};
        int eq[5] = '{32767, 32767, 32767, -32768, -32767};
        int er[5] = '{0, 0, 0, 0, 255};
        logic eo[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        int lat;
        for (int i = 0; i < 5; i++) begin
            start(va[i], vb[i]);
            wait_done(lat);
            tests++;
            if (bus.quot !== 16'(eq[i]) || bus.rem !== 9'(er[i]) || bus.ovf !== eo[i] || bus.div0 !== 1'b0) begin
                $display("FAIL saturation %0d/%0d: quot=%0d rem=%0d ovf=%b div0=%b, want %0d %0d %b 0",
                         va[i], vb[i], bus.quot, bus.rem, bus.ovf, bus.div0, eq[i], er[i], eo[i]);
                fails++;
            end
            retire();
        end
    endtask

    task automatic test_div0;
        int va[2] = '{5, -5};
        int eq[2] = '{32767, -32768};
        int lat;
        for (int i = 0; i < 2; i++) begin
            start(va[i], 0);
            wait_done(lat);
            tests++;
            if (lat != 25) begin
                $display("FAIL div0_latency %0d/0: got %0d edges, want 25", va[i], lat);
                fails++;
            end
            tests++;
            if (bus.quot !== 16'(eq[i]) || bus.rem !== 9'sd0 || bus.ovf !== 1'b0 || bus.div0 !== 1'b1) begin
                $display("FAIL div0 %0d/0: quot=%0d rem=%0d ovf=%b div0=%b, want %0d 0 0 1",
                         va[i], bus.quot, bus.rem, bus.ovf, bus.div0, eq[i]);
                fails++;
            end
            retire();
        end
    endtask

    task automatic test_backpressure;
        int lat;
        start(1000, 7);
        wait_done(lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge ap_clk);
            bus.in_valid = 1'b1;
            bus.din0 = 24'sd5;
            bus.din1 = 9'sd0;
            tests++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.quot !== 16'sd142 || bus.rem !== 9'sd6 ||
                bus.div0 !== 1'b0) begin
                $display("FAIL backpressure cycle %0d: out_valid=%b in_ready=%b quot=%0d rem=%0d div0=%b, want 1 0 142 6 0",
                         i, bus.out_valid, bus.in_ready, bus.quot, bus.rem, bus.div0);
                fails++;
            end
        end
        bus.in_valid = 1'b0;
        retire();
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            $display("FAIL backpressure_release: in_ready=%b out_valid=%b, want 1 0", bus.in_ready, bus.out_valid);
            fails++;
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        start(1000, 7);
        repeat (10) @(posedge ap_clk);
        #3 ap_rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.in_ready, bus.out_valid, bus.ovf, bus.div0, bus.quot, bus.rem} !== {4'b1000, 25'd0}) begin
            $display("FAIL reset_mid: in_ready=%b out_valid=%b ovf=%b div0=%b quot=%0d rem=%0d, want 1 0 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.ovf, bus.div0, bus.quot, bus.rem);
            fails++;
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        start(100, -3);
        wait_done(lat);
        tests++;
        if (lat != 25) begin
            $display("FAIL reset_mid_latency: got %0d edges, want 25", lat);
            fails++;
        end
        tests++;
        if (bus.quot !== -16'sd33 || bus.rem !== 9'sd1 || bus.ovf !== 1'b0 || bus.div0 !== 1'b0) begin
            $display("FAIL reset_mid 100/-3: quot=%0d rem=%0d ovf=%b div0=%b, want -33 1 0 0",
                     bus.quot, bus.rem, bus.ovf, bus.div0);
            fails++;
        end
        retire();
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.din0 = '0;
        bus.din1 = '0;
        test_reset();
        test_basic();
        test_signs();
        test_saturation();
        test_div0();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
